// File: rtl/chan_pack_pkg.sv
// Shared constants and channel packing helpers for the chan_pack FIFO.
// Helpers work on the widest legal channel count; callers pad or slice to M.
package chan_pack_pkg;

    localparam int M_DEF     = 2;
    localparam int DEPTH_DEF = 4;
    localparam int CW_DEF    = 8;
    localparam int CHAN_MAX  = 64;

    typedef logic chan_arr_t [CHAN_MAX];
    typedef logic [0:CHAN_MAX-1] chan_vec_t;

    // Element i lands in bit i, so element 0 becomes the MSB.
    function automatic chan_vec_t pack_chan(input chan_arr_t a);
        chan_vec_t v;
        for (int i = 0; i < CHAN_MAX; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic chan_arr_t unpack_chan(input chan_vec_t v);
        chan_arr_t a;
        for (int i = 0; i < CHAN_MAX; i++) a[i] = v[i];
        return a;
    endfunction

endpackage

// File: rtl/chan_pack_mem.sv
// DEPTH x M storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the FIFO control logic.
module chan_pack_mem
    import chan_pack_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [0:M-1]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [0:M-1]  rdata
);

    logic [0:M-1] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/chan_pack_fifo.sv
// FIFO of M-bit channel samples with a sticky overflow flag.
// Define CHAN_PACK_OVF_CNT_EN to add the saturating ovf_cnt dropped-sample counter.
module chan_pack_fifo
    import chan_pack_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                         clock,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         d_valid,
    input  logic                         d [M],
    output logic                         d_ready,
    output logic                         q_valid,
    input  logic                         q_ready,
    output logic [0:M-1]                 q,
    output logic                         q_arr [M],
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
`ifdef CHAN_PACK_OVF_CNT_EN
    ,
    output logic [CW-1:0]                ovf_cnt
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [AW-1:0] wptr, rptr;
    logic          full, wr_en, rd_en, drop, mem_we;
    logic [0:M-1]  wdata, rdata;
    chan_arr_t     d_full;
    chan_vec_t     d_vec;
    logic          unused_pad;

    for (genvar i = 0; i < CHAN_MAX; i++) begin : g_pad
        if (i < M) begin : g_used
            assign d_full[i] = d[i];
        end else begin : g_zero
            assign d_full[i] = 1'b0;
        end
    end

    assign d_vec      = pack_chan(d_full);
    assign wdata      = d_vec[0:M-1];
    assign unused_pad = ^d_vec;

    assign full    = (count == CNTW'(DEPTH));
    assign d_ready = ~full;
    assign q_valid = (count != '0);
    assign wr_en   = d_valid & d_ready;
    assign rd_en   = q_valid & q_ready;
    // A full FIFO drops the sample even when a read frees a slot this cycle.
    assign drop    = d_valid & full;
    assign mem_we  = wr_en & rstn & ~flush;

    chan_pack_mem #(
        .M     (M),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (!rstn || flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            if (wr_en && !rd_en)      count <= count + 1'b1;
            else if (rd_en && !wr_en) count <= count - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef CHAN_PACK_OVF_CNT_EN
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Survives flush; only reset clears the lifetime drop count.
    always_ff @(posedge clock) begin
        if (!rstn)              ovf_cnt <= '0;
        else if (drop && !flush) ovf_cnt <= sat_inc(ovf_cnt);
    end
`endif

    assign q = q_valid ? rdata : '0;

    for (genvar i = 0; i < M; i++) begin : g_qarr
        assign q_arr[i] = q[i];
    end

endmodule

// File: tb/tb_chan_pack_fifo.sv
// Randomized and directed bench for chan_pack_fifo against a queue-based model.
// Covers the CHAN_PACK_OVF_CNT_EN counter when that macro is defined.
module tb_chan_pack_fifo;

    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic             clock = 1'b0;
    logic             rstn;
    logic             flush;
    logic             d_valid;
    logic             d [M];
    logic             d_ready;
    logic             q_valid;
    logic             q_ready;
    logic [0:M-1]     q;
    logic             q_arr [M];
    logic [2:0]       count;
    logic             overflow;
`ifdef CHAN_PACK_OVF_CNT_EN
    logic [CW-1:0]    ovf_cnt;
`endif

    chan_pack_fifo #(.M(M), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock    (clock),
        .rstn     (rstn),
        .flush    (flush),
        .d_valid  (d_valid),
        .d        (d),
        .d_ready  (d_ready),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q        (q),
        .q_arr    (q_arr),
        .count    (count),
        .overflow (overflow)
`ifdef CHAN_PACK_OVF_CNT_EN
        ,
        .ovf_cnt  (ovf_cnt)
`endif
    );

    always #5 clock = ~clock;

    logic [0:M-1] mq [$];
    bit           m_ovf;
    int           m_ovf_cnt;
    int           n_assert;
    int           n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [0:M-1] exp_q;
        logic [0:M-1] arr_v;
        exp_q = (mq.size() != 0) ? mq[0] : '0;
        for (int i = 0; i < M; i++) arr_v[i] = q_arr[i];
        chk({tag, ".count"},    count,    mq.size());
        chk({tag, ".q_valid"},  q_valid,  mq.size() != 0);
        chk({tag, ".d_ready"},  d_ready,  mq.size() != DEPTH);
        chk({tag, ".q"},        q,        exp_q);
        chk({tag, ".q_arr"},    arr_v,    exp_q);
        chk({tag, ".overflow"}, overflow, m_ovf);
`ifdef CHAN_PACK_OVF_CNT_EN
        chk({tag, ".ovf_cnt"},  ovf_cnt,  m_ovf_cnt);
`endif
    endtask

    task automatic step(input bit dv, input logic [0:M-1] dat, input bit qr,
                        input bit fl, input string tag);
        bit full, wr, rd;
        d_valid = dv;
        for (int i = 0; i < M; i++) d[i] = dat[i];
        q_ready = qr;
        flush   = fl;
        full = (mq.size() == DEPTH);
        wr   = dv && !full;
        rd   = qr && (mq.size() != 0);
        @(posedge clock);
        #1;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(dat);
            if (dv && full) begin
                m_ovf = 1'b1;
                if (m_ovf_cnt < (2**CW) - 1) m_ovf_cnt++;
            end
        end
        d_valid = 1'b0;
        q_ready = 1'b0;
        flush   = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        d_valid = 1'b1;
        q_ready = 1'b1;
        @(posedge clock);
        #1;
        mq.delete();
        m_ovf     = 1'b0;
        m_ovf_cnt = 0;
        rstn    = 1'b1;
        d_valid = 1'b0;
        q_ready = 1'b0;
        check_all(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_ovf    = 1'b0;
        m_ovf_cnt = 0;
        rstn     = 1'b0;
        flush    = 1'b0;
        d_valid  = 1'b0;
        q_ready  = 1'b0;
        for (int i = 0; i < M; i++) d[i] = 1'b0;
        @(posedge clock);
        #1;
        do_reset("reset");

        // Single write of d='{1,0,1,1}.
        step(1'b1, 4'b1011, 1'b0, 1'b0, "single_wr");
        chk("single_wr.q_const", q, 4'b1011);
        chk("single_wr.count_const", count, 3'd1);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "single_rd");

        // Five writes into a four-deep FIFO.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'(k * 3 + 5), 1'b0, 1'b0, "fill5");
            if (k == 3) chk("fill5.d_ready_full", d_ready, 1'b0);
        end
        chk("fill5.overflow_const", overflow, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 4'b0000, 1'b1, 1'b0, "drain4");

        // Full FIFO sees a drop and a read together.
        step(1'b0, 4'b0000, 1'b0, 1'b1, "flush_a");
        for (int k = 0; k < 4; k++) step(1'b1, 4'($urandom), 1'b0, 1'b0, "fill_a");
        step(1'b1, 4'b1111, 1'b1, 1'b0, "drop_rd");
        chk("drop_rd.count_const", count, 3'd3);
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 1'b1, 1'b0, "drain_a");

        // Simultaneous read and write across pointer wrap.
        step(1'b0, 4'b0000, 1'b0, 1'b1, "flush_b");
        for (int k = 0; k < 2; k++) step(1'b1, 4'($urandom), 1'b0, 1'b0, "pre_alt");
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 4'($urandom), 1'b1, 1'b0, "alt");
            chk("alt.count_const", count, 3'd2);
        end

        // Flush with a concurrent write.
        step(1'b0, 4'b0000, 1'b0, 1'b1, "flush_c");
        for (int k = 0; k < 3; k++) step(1'b1, 4'($urandom), 1'b0, 1'b0, "fill_c");
        step(1'b1, 4'b1010, 1'b0, 1'b1, "flush_wr");
        chk("flush_wr.q_zero", q, 4'b0000);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0), "rand");
        end

        // Six drops from a full FIFO, then reset mid-stream.
        do_reset("reset_b");
        for (int k = 0; k < 4; k++) step(1'b1, 4'($urandom), 1'b0, 1'b0, "fill_d");
        for (int k = 0; k < 6; k++) step(1'b1, 4'($urandom), 1'b0, 1'b0, "drop6");
`ifdef CHAN_PACK_OVF_CNT_EN
        chk("drop6.ovf_sat", ovf_cnt, 2'd3);
`endif
        step(1'b0, 4'b0000, 1'b1, 1'b1, "flush_keep");
        do_reset("reset_mid");
        chk("reset_mid.count_const", count, 3'd0);
        chk("reset_mid.d_ready_const", d_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_pack_fifo.md
CHAN_PACK_FIFO -- requirements
Module: chan_pack_fifo

Interface
REQ-001 Parameter M, default 2: number of 1-bit channels; legal range 1..64.
REQ-002 Parameter DEPTH, default 4: number of FIFO entries; power of two, at least 2.
REQ-003 Parameter CW, default 8: overflow-counter width; used only when CHAN_PACK_OVF_CNT_EN is defined.
REQ-004 The block SHALL use one clock, `clock`, and a synchronous active-low reset, `rstn`.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 rstn  input  1  synchronous, active-low reset.
REQ-007 flush  input  1  synchronous clear of all entries and of the overflow flag.
REQ-008 d_valid  input  1  a channel sample is offered.
REQ-009 d  input  logic unpacked [M]  channel sample, one bit per element.
REQ-010 d_ready  output  1  FIFO can accept a sample.
REQ-011 q_valid  output  1  head entry is present.
REQ-012 q_ready  input  1  consumer accepts the head entry.
REQ-013 q  output  packed [0:M-1]  head entry; q[i] = d[i] as written, so d[0] is the MSB.
REQ-014 q_arr  output  logic unpacked [M]  head entry in unpacked form; q_arr[i] = q[i].
REQ-015 count  output  $clog2(DEPTH+1)  number of entries held.
REQ-016 overflow  output  1  sticky flag: a sample was dropped.
REQ-017 ovf_cnt  output  CW  saturating count of dropped samples; present only with the macro.

Function
REQ-018 Write occurs when d_valid=1 and d_ready=1; d_ready SHALL equal (count != DEPTH).
REQ-019 Read occurs when q_valid=1 and q_ready=1; q_valid SHALL equal (count != 0).
REQ-020 Ordering SHALL be first-in first-out.
REQ-021 Latency: a write into an empty FIFO SHALL raise q_valid on the next cycle, with q holding that sample.
REQ-022 q and q_arr SHALL be driven from registered storage at the read pointer, with no combinational path from d.
REQ-023 q and q_arr SHALL be all-zero whenever q_valid=0.
REQ-024 A read and a write in the same cycle SHALL leave count unchanged, and both pointers SHALL advance.
REQ-025 When full (count=DEPTH), d_valid=1 SHALL drop the sample, set overflow=1, and leave storage untouched, even if a read occurs in the same cycle.
REQ-026 When empty, q_ready SHALL be ignored.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 flush=1 SHALL, on that edge, set count=0, both pointers=0 and overflow=0; any concurrent read or write is discarded; flush does not clear ovf_cnt.
REQ-029 overflow SHALL stay set until flush or reset.

Reset
REQ-030 With rstn=0 at a rising clock edge, the block SHALL set count=0, pointers=0, q_valid=0, d_ready=1, overflow=0 and ovf_cnt=0.
REQ-031 q and q_arr SHALL be 0 after reset; storage contents need not be reset.
REQ-032 Reset SHALL take priority over flush, read and write; a reset mid-stream discards all entries.

Configuration
REQ-033 With macro CHAN_PACK_OVF_CNT_EN defined, ovf_cnt SHALL increment once per dropped sample.
REQ-034 ovf_cnt SHALL saturate at 2^CW-1 and be cleared only by reset.
REQ-035 Without CHAN_PACK_OVF_CNT_EN, the port ovf_cnt and its logic SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-036 Package chan_pack_pkg SHALL hold the default parameter constants and a function packing an unpacked [M] array into a packed [0:M-1] vector, plus its inverse.
REQ-037 Storage SHALL be one sub-module, chan_pack_mem, with one write port and one asynchronous read port, DEPTH x M bits.
REQ-038 Pointer, count and flag logic SHALL reside in chan_pack_fifo.

Verification
REQ-039 Single write, M=4, d='{1,0,1,1}, DEPTH=4 -> next cycle: q_valid=1, q=4'b1011, q_arr='{1,0,1,1}, count=1.
REQ-040 Five writes with no reads, DEPTH=4 -> after the fourth write, d_ready=0 and count=4; the fifth write sets overflow=1; with the macro, ovf_cnt=1; the four reads that follow return the first four samples in order.
REQ-041 Full FIFO with d_valid=1 and q_ready=1 in the same cycle -> count=3, overflow=1, and the dropped sample never appears on q.
REQ-042 Alternating read and write for 10 cycles with DEPTH=4 -> pointers wrap, count stays constant, and data matches a reference queue.
REQ-043 Three entries, then flush=1 together with d_valid=1 -> next cycle: count=0, q_valid=0, q=0, overflow=0.
REQ-044 Macro defined, CW=2, six dropped samples -> ovf_cnt=3 (saturated); rstn=0 for one edge -> ovf_cnt=0, count=0, d_ready=1.
